// File: rtl/pmt_pulse_emulator_pkg.sv
// pmt_emu_pkg: shared state encoding, LFSR taps and helpers for the
// PMT pulse emulator and its LFSR sub-block.
package pmt_emu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } pmt_state_e;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] RATE_ALWAYS = 32'hFFFF_FFFF;
    localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == COUNT_MAX) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pmt_pulse_emulator_if.sv
// pmt_pulse_emulator_if: control/status bundle of the PMT pulse emulator.
// Optional macro PMT_EMU_PERIODIC_EN adds periodic_mode / period_cycles.
interface pmt_pulse_emulator_if;

    logic        enable;
    logic        light_source_in;
    logic [31:0] rate_on;
    logic [31:0] rate_off;
    logic        clear_counts;
    logic        pulse_out;
    logic        busy;
    logic [31:0] count_on;
    logic [31:0] count_off;
`ifdef PMT_EMU_PERIODIC_EN
    logic        periodic_mode;
    logic [31:0] period_cycles;
`endif

`ifdef PMT_EMU_PERIODIC_EN
    modport master (
        output enable, light_source_in, rate_on, rate_off, clear_counts,
               periodic_mode, period_cycles,
        input  pulse_out, busy, count_on, count_off
    );
    modport slave (
        input  enable, light_source_in, rate_on, rate_off, clear_counts,
               periodic_mode, period_cycles,
        output pulse_out, busy, count_on, count_off
    );
`else
    modport master (
        output enable, light_source_in, rate_on, rate_off, clear_counts,
        input  pulse_out, busy, count_on, count_off
    );
    modport slave (
        input  enable, light_source_in, rate_on, rate_off, clear_counts,
        output pulse_out, busy, count_on, count_off
    );
`endif

endinterface

// File: rtl/pmt_pulse_emulator_lfsr.sv
// galois_lfsr32: free-running 32-bit Galois LFSR, reusable by other
// stimulus blocks. A zero seed would lock up, so it is replaced by 1.
module galois_lfsr32
    import pmt_emu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] state
);

    localparam logic [31:0] SEED_EFF = (SEED == '0) ? 32'h1 : SEED;

    // Advance every clock while out of reset; reload the seed on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED_EFF;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/pmt_pulse_emulator.sv
// pmt_pulse_emulator: synthetic PMT pulse source for self-test of the
// photon-counting lock-in path. Bernoulli fires from an LFSR, fixed pulse
// width and dead time, per-phase saturating emitted-pulse counters.
// Optional macro PMT_EMU_PERIODIC_EN adds a deterministic periodic mode.
module pmt_pulse_emulator
    import pmt_emu_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH_CYCLES = 5,
    parameter int unsigned DEAD_TIME_CYCLES   = 10,
    parameter logic [31:0] LFSR_SEED          = 32'h1
) (
    input  logic                 clock_50_mhz,
    input  logic                 reset_n,
    pmt_pulse_emulator_if.slave  bus
);

    localparam logic [31:0] PW_LAST = 32'(PULSE_WIDTH_CYCLES - 1);
    localparam logic [31:0] DT_LAST =
        (DEAD_TIME_CYCLES == 0) ? '0 : 32'(DEAD_TIME_CYCLES - 1);

    pmt_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  sync_q;
    logic        phase;
    logic [31:0] lfsr_value;
    logic [31:0] thr;
    logic        lfsr_fire;
    logic        fire;
    logic        fire_idle;
    logic        pulse_q;
    logic [31:0] count_on_q;
    logic [31:0] count_off_q;

    galois_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock_50_mhz),
        .reset_n (reset_n),
        .state   (lfsr_value)
    );

    // Two-flop synchroniser for the asynchronous modulation phase.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.light_source_in};
        end
    end

    assign phase     = sync_q[1];
    assign thr       = phase ? bus.rate_on : bus.rate_off;
    // All-ones must always fire; a plain compare would miss lfsr == all-ones.
    assign lfsr_fire = (thr == RATE_ALWAYS) || (lfsr_value < thr);

`ifdef PMT_EMU_PERIODIC_EN
    logic [31:0] idle_cnt_q;
    logic [31:0] period_last;

    assign period_last = (bus.period_cycles == '0) ? '0 : (bus.period_cycles - 32'd1);
    assign fire = bus.enable &
                  (bus.periodic_mode ? (idle_cnt_q == period_last) : lfsr_fire);

    // Idle-cycle counter for periodic mode; cleared outside IDLE, when disabled and on a fire.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else if ((state_q != IDLE) || !bus.enable || !bus.periodic_mode || fire_idle) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end
`else
    assign fire = bus.enable & lfsr_fire;
`endif

    assign fire_idle = (state_q == IDLE) && fire;

    // State and phase-length counter register.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> PULSE (width) -> DEAD (dead time, skipped if zero) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fire_idle) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == PW_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD_TIME_CYCLES == 0) ? IDLE : DEAD;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DEAD: begin
                if (cnt_q == DT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered pulse output, high exactly while the FSM sits in PULSE.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= (state_d == PULSE);
        end
    end

    // Per-phase emitted-pulse counters; clear has priority over a coincident fire.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            count_on_q  <= '0;
            count_off_q <= '0;
        end else if (bus.clear_counts) begin
            count_on_q  <= '0;
            count_off_q <= '0;
        end else if (fire_idle) begin
            if (phase) begin
                count_on_q <= sat_inc(count_on_q);
            end else begin
                count_off_q <= sat_inc(count_off_q);
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.count_on  = count_on_q;
    assign bus.count_off = count_off_q;

endmodule

// File: tb/tb_pmt_pulse_emulator.sv
// tb_pmt_pulse_emulator: self-checking bench for pmt_pulse_emulator.
// A behavioural reference model predicts every pulse start and the two
// counters; pulse starts are queued and matched by a pulse monitor.
module tb_pmt_pulse_emulator;

    localparam int          PW   = 5;
    localparam int          DT   = 10;
    localparam logic [31:0] SEED = 32'h1;

    logic   clock_50_mhz = 1'b0;
    logic   reset_n;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    pmt_pulse_emulator_if bus();

    pmt_pulse_emulator #(
        .PULSE_WIDTH_CYCLES (PW),
        .DEAD_TIME_CYCLES   (DT),
        .LFSR_SEED          (SEED)
    ) dut (
        .clock_50_mhz (clock_50_mhz),
        .reset_n      (reset_n),
        .bus          (bus.slave)
    );

    always #10 clock_50_mhz = ~clock_50_mhz;

    // Free-running posedge count used as the time base for pulse starts.
    always @(posedge clock_50_mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_lfsr, m_on, m_off, m_thr;
    logic        m_s1, m_s2, m_fire;
    logic        sb_preset = 1'b0;
    int          m_hold;
    longint      exp_q[$];
`ifdef PMT_EMU_PERIODIC_EN
    logic [31:0] m_idle;
`endif

    always_comb begin
        m_thr  = m_s2 ? bus.rate_on : bus.rate_off;
        m_fire = (m_hold == 0) && bus.enable &&
                 ((m_thr == 32'hFFFF_FFFF) || (m_lfsr < m_thr));
`ifdef PMT_EMU_PERIODIC_EN
        if (bus.periodic_mode)
            m_fire = (m_hold == 0) && bus.enable &&
                     (m_idle == ((bus.period_cycles == 0) ? 32'd0 : bus.period_cycles - 32'd1));
`endif
    end

    always @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr <= SEED;
            m_s1   <= 1'b0;
            m_s2   <= 1'b0;
            m_hold <= 0;
            m_on   <= '0;
            m_off  <= '0;
`ifdef PMT_EMU_PERIODIC_EN
            m_idle <= '0;
`endif
        end else begin
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
            m_s1   <= bus.light_source_in;
            m_s2   <= m_s1;
            m_hold <= m_fire ? (PW + DT) : ((m_hold > 0) ? m_hold - 1 : 0);
            if (m_fire) exp_q.push_back(cyc + 1);
            if (sb_preset) m_on <= 32'hFFFF_FFFF;
            else if (bus.clear_counts) begin
                m_on  <= '0;
                m_off <= '0;
            end else if (m_fire) begin
                if (m_s2) m_on  <= (m_on  == 32'hFFFF_FFFF) ? m_on  : m_on  + 1;
                else      m_off <= (m_off == 32'hFFFF_FFFF) ? m_off : m_off + 1;
            end
`ifdef PMT_EMU_PERIODIC_EN
            if (m_hold != 0 || !bus.enable || m_fire || !bus.periodic_mode) m_idle <= '0;
            else m_idle <= m_idle + 1;
`endif
        end
    end

    // ---------------- pulse monitor ----------------
    initial begin
        logic   prev;
        longint rise;
        longint e;
        prev = 1'b0;
        rise = 0;
        forever begin
            @(negedge clock_50_mhz);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (bus.pulse_out && !prev) begin
                    rise = cyc;
                    if (exp_q.size() == 0) begin
                        check("pulse_unexpected", cyc, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_start", cyc, e);
                    end
                end else if (!bus.pulse_out && prev) begin
                    check("pulse_width", cyc - rise, PW);
                end
                prev = bus.pulse_out;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step_cycles(input int n);
        repeat (n) @(negedge clock_50_mhz);
    endtask

    task automatic wait_rise(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clock_50_mhz);
            if (bus.pulse_out) break;
        end
        check(tag, bus.pulse_out, 1);
    endtask

    task automatic clear_pulse();
        bus.clear_counts = 1'b1;
        step_cycles(1);
        bus.clear_counts = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_count_on"},  bus.count_on,  m_on);
        check({tag, "_count_off"}, bus.count_off, m_off);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // Watchdog: the run must end on its own.
    initial begin
        #1_600_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        longint t0;
        logic [31:0] base_on;
        reset_n             = 1'b0;
        bus.enable          = 1'b0;
        bus.light_source_in = 1'b0;
        bus.rate_on         = '0;
        bus.rate_off        = '0;
        bus.clear_counts    = 1'b0;
`ifdef PMT_EMU_PERIODIC_EN
        bus.periodic_mode   = 1'b0;
        bus.period_cycles   = '0;
`endif
        #25;
        check("rst_pulse_out", bus.pulse_out, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_count_on",  bus.count_on, 0);
        check("rst_count_off", bus.count_off, 0);
        check("rst_lfsr",      dut.lfsr_value, SEED);
        step_cycles(1);
        reset_n = 1'b1;

        // 1: always-fire, light off: 100 pulses in 1600 cycles, period 16
        bus.rate_on  = 32'hFFFF_FFFF;
        bus.rate_off = 32'hFFFF_FFFF;
        bus.enable   = 1'b1;
        step_cycles(1600);
        bus.enable = 1'b0;
        step_cycles(20);
        check("t1_total", bus.count_on + bus.count_off, 100);
        check_counts("t1");
        check("t1_busy", bus.busy, 0);

        // 2: light on always fires, light off never; then switch light off
        clear_pulse();
        bus.light_source_in = 1'b1;
        bus.rate_off        = '0;
        step_cycles(4);
        bus.enable = 1'b1;
        step_cycles(40);
        bus.light_source_in = 1'b0;
        step_cycles(1600);
        bus.enable = 1'b0;
        check("t2_count_on",  bus.count_on, 3);
        check("t2_count_off", bus.count_off, 0);
        check("t2_pulse_low", bus.pulse_out, 0);
        check_counts("t2");

        // 3: p = 0.25 with light on, compared against the model and a sanity band
        clear_pulse();
        bus.rate_on         = 32'h4000_0000;
        bus.light_source_in = 1'b1;
        step_cycles(4);
        bus.enable = 1'b1;
        step_cycles(30000);
        bus.enable = 1'b0;
        step_cycles(20);
        check_counts("t3");
        check("t3_rate_band", (bus.count_on >= 1200) && (bus.count_on <= 1875), 1);

        // 4: enable dropped two cycles into a pulse
        clear_pulse();
        bus.rate_on         = 32'hFFFF_FFFF;
        bus.rate_off        = 32'hFFFF_FFFF;
        bus.light_source_in = 1'b0;
        step_cycles(4);
        bus.enable = 1'b1;
        wait_rise("t4_rise", 20);
        step_cycles(2);
        bus.enable = 1'b0;
        check("t4_busy_mid", bus.busy, 1);
        step_cycles(20);
        check("t4_busy_after", bus.busy, 0);
        check("t4_count_off", bus.count_off, 1);
        check_counts("t4");

        // 5: clear coincident with a fire, then saturation
        clear_pulse();
        bus.light_source_in = 1'b1;
        step_cycles(4);
        bus.enable = 1'b1;
        step_cycles(100);
        bus.enable = 1'b0;
        step_cycles(20);
        check("t5_count_seven", bus.count_on, 7);
        bus.enable       = 1'b1;
        bus.clear_counts = 1'b1;
        step_cycles(1);
        bus.enable       = 1'b0;
        bus.clear_counts = 1'b0;
        check("t5_clear_wins", bus.count_on, 0);
        check("t5_pulse_emitted", bus.pulse_out, 1);
        step_cycles(20);
        check_counts("t5a");
        force dut.count_on_q = 32'hFFFF_FFFF;
        sb_preset = 1'b1;
        step_cycles(1);
        release dut.count_on_q;
        sb_preset = 1'b0;
        base_on = bus.count_on;
        check("t5_preset", base_on, 32'hFFFF_FFFF);
        bus.enable = 1'b1;
        step_cycles(1);
        bus.enable = 1'b0;
        check("t5_sat_pulse", bus.pulse_out, 1);
        check("t5_saturated", bus.count_on, 32'hFFFF_FFFF);
        step_cycles(20);
        check_counts("t5b");

        // 6: asynchronous reset in the middle of a pulse
        bus.enable = 1'b1;
        wait_rise("t6_rise", 20);
        step_cycles(2);
        #5;
        reset_n = 1'b0;
        #1;
        check("t6_pulse_drop", bus.pulse_out, 0);
        check("t6_busy_drop",  bus.busy, 0);
        check("t6_count_on",   bus.count_on, 0);
        bus.enable = 1'b0;
        step_cycles(2);
        reset_n = 1'b1;
        check("t6_lfsr_seed", dut.lfsr_value, SEED);
        step_cycles(1);
        check("t6_lfsr_step", dut.lfsr_value, m_lfsr);
        check("t6_pulse_idle", bus.pulse_out, 0);

`ifdef PMT_EMU_PERIODIC_EN
        // 7: periodic mode, period_cycles = 20 gives one pulse per 35 clocks
        clear_pulse();
        bus.rate_on       = '0;
        bus.rate_off      = '0;
        bus.periodic_mode = 1'b1;
        bus.period_cycles = 32'd20;
        bus.enable        = 1'b1;
        wait_rise("t7_first", 40);
        t0 = cyc;
        step_cycles(PW);
        wait_rise("t7_second", 60);
        check("t7_period", cyc - t0, 35);
        bus.enable        = 1'b0;
        bus.periodic_mode = 1'b0;
        step_cycles(40);
        check_counts("t7");
`else
        t0 = cyc;
`endif

        check("final_sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmt_pulse_emulator.md
Name: pmt_pulse_emulator

Overview:
Synthetic PMT source for bench and on-board self-test of the photon-counting lock-in path. It drives a PMT-like pulse train whose pulse rate depends on the light-source modulation phase. It takes the light_source_pin drive as its input and emits on the net normally driven by the PMT discriminator. Pulses are Bernoulli per clock from an LFSR, with a fixed pulse width and a fixed dead time. Per-phase emitted-pulse counters give the ground truth that the counter's add/subtract tallies are checked against.

Parameters:
PULSE_WIDTH_CYCLES, 5, pulse high time in clocks (100 ns at 50 MHz); must be ≥1
DEAD_TIME_CYCLES, 10, forced low time after each pulse; 0 allowed
LFSR_SEED, 32'h1, initial LFSR state; a value of 0 is replaced by 1

Ports:
clock_50_mhz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  allow new pulses
light_source_in  input  1  modulation phase, asynchronous to the clock; 2-FF synchronised internally
rate_on  input  32  per-clock fire threshold while light is on
rate_off  input  32  per-clock fire threshold while light is off
clear_counts  input  1  single-cycle pulse; zeroes both counters
pulse_out  output  1  emulated PMT pulse, registered
busy  output  1  high in PULSE or DEAD
count_on  output  32  pulses emitted with light on, saturating
count_off  output  32  pulses emitted with light off, saturating

Behaviour:
- Reset (async assert, sync release): pulse_out=0, busy=0, both counts=0, state=IDLE, LFSR=seed, synchroniser=0.
- phase = second synchroniser flop; 2-cycle latency from light_source_in.
- LFSR: 32-bit Galois, taps 32'h80200003; advances every clock in every state while out of reset.
- thr = phase ? rate_on : rate_off.
- fire = enable & (thr == 32'hFFFFFFFF | lfsr < thr). thr=0 never fires. Probability per IDLE cycle is thr/2^32.
- IDLE: on fire, go to PULSE; pulse_out=1 from the next cycle; the phase at the fire cycle is latched into the matching counter.
- PULSE: stays for exactly PULSE_WIDTH_CYCLES cycles with pulse_out=1. Then goes to DEAD, or to IDLE if DEAD_TIME_CYCLES=0.
- DEAD: pulse_out=0 for DEAD_TIME_CYCLES cycles, then IDLE. Evaluation in IDLE starts the same cycle it is entered.
- Minimum pulse period = 1+PULSE_WIDTH_CYCLES+DEAD_TIME_CYCLES clocks (16 at defaults).
- Phase changes during PULSE/DEAD do not alter the current pulse or its attribution.
- enable falling mid-pulse: the current PULSE+DEAD completes, then no new fires.
- Counters increment on the fire cycle and saturate at 32'hFFFFFFFF.
- clear_counts zeroes both counters next cycle. If clear and fire coincide, clear wins and that pulse is not counted; pulse_out is unaffected.
- Async reset mid-pulse: pulse_out drops immediately, with no glitch on release.

Optional Feature:
PMT_EMU_PERIODIC_EN
- Defined: adds ports periodic_mode (in, 1) and period_cycles (in, 32).
- With periodic_mode=1, fire is deterministic: an idle counter increments each IDLE cycle and fires when it reaches max(period_cycles,1)-1, then clears. The counter clears on leaving IDLE and when enable=0. Phase attribution and counters are unchanged.
- Not defined: no ports or counter exist; LFSR mode only.

Decomposition:
- Package pmt_emu_pkg: state enum {IDLE, PULSE, DEAD}, LFSR_TAPS=32'h80200003, RATE_ALWAYS=32'hFFFFFFFF.
- Sub-module galois_lfsr32 (clock, reset_n, seed parameter, state out). It is reusable by other test-stimulus blocks.

Test Plan:
1. rate_on=rate_off=32'hFFFFFFFF, enable=1, 1600 cycles → exactly 100 pulses, each high 5 cycles, 16-cycle period; count_on or count_off sums to 100.
2. light_source_in=1, rate_on=32'hFFFFFFFF, rate_off=0, then light_source_in=0 for 1600 cycles → count_off unchanged and pulse_out stays 0 once the in-flight pulse ends (≤2+15 cycles after the toggle).
3. rate_on=32'h40000000 (p=0.25), light on, 10^6 cycles → count_on within ±3σ of the dead-time-corrected expectation (~0.25/(1+0.25·15) per cycle, ≈52 600).
4. enable dropped 2 cycles into a pulse → pulse stays high 5 cycles total, DEAD completes, no further pulses, busy=0 afterwards.
5. clear_counts asserted on a fire cycle with count_on=7 → count_on=0 next cycle, pulse still emitted; count preset to 32'hFFFFFFFF plus another fire → stays 32'hFFFFFFFF.
6. reset_n asserted mid-pulse → pulse_out=0 within the same cycle; after release, the first LFSR value equals LFSR_SEED. (With PMT_EMU_PERIODIC_EN, period_cycles=20 gives a pulse every 35 clocks at defaults.)
